// File: rtl/filter_pkg.sv
// Shared mode encoding for the frame-synchronous filter controller and the
// pixel filter datapath.
package filter_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_GRAY   = 2'b01;
  localparam logic [1:0] MODE_NEG    = 2'b10;

  // Debounce counter width; covers DEBOUNCE_CYCLES up to 2^24-1.
  localparam int CNT_W = 24;

  // Button cycles normal -> gray -> negative -> normal; the unused code 11
  // falls back to normal.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      MODE_NORMAL: r = MODE_GRAY;
      MODE_GRAY:   r = MODE_NEG;
      default:     r = MODE_NORMAL;
    endcase
    return r;
  endfunction

  // Host requests of the unused code 11 are treated as normal.
  function automatic logic [1:0] sanitize_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_NORMAL : m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the 0->1 transition of the debounced level.
module btn_debounce
  import filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q,  sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             press_q, press_d;

  // Counter runs only while the synchronized sample disagrees with the
  // debounced level; any agreement restarts the stability window.
  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = ~level_q;
      cnt_d   = '0;
      press_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer, debounce state and press pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/filter_mode_ctrl.sv
// Frame-synchronous filter mode controller: queues a mode from the button
// or the host port and commits it to `select` at the start of vsync.
//
// Host handshake: a request transfers on a rising clk edge where
// cfg_valid && cfg_ready; cfg_ready is low while a mode is queued, and the
// host must hold cfg_valid/cfg_mode stable until the transfer happens.
module filter_mode_ctrl
  import filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int VS_ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       vsync,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_mode,
  output logic       cfg_ready,
  output logic [1:0] select,
  output logic       pending,
  output logic       mode_changed
);

  localparam logic VS_IDLE = (VS_ACTIVE_LOW != 0);

  logic       press;
  logic       vs_q;
  logic       boundary;
  logic       xfer;
  logic [1:0] base_mode;

  logic [1:0] select_q,  select_d;
  logic [1:0] pend_q,    pend_d;
  logic       pending_q, pending_d;
  logic       changed_q, changed_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn),
    .press_o(press)
  );

  // Boundary strobe: the first cycle vsync is seen at its active level.
  assign boundary = VS_IDLE ? (vs_q & ~vsync) : (~vs_q & vsync);
  assign xfer     = cfg_valid & ~pending_q;
  assign base_mode = pending_q ? pend_q : select_q;

  // Commit the queued mode at a boundary, then let a host transfer or a
  // press (host wins) refill the queue in the same cycle.
  always_comb begin
    select_d  = select_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    changed_d = 1'b0;
    if (boundary && pending_q) begin
      select_d  = pend_q;
      pending_d = 1'b0;
      changed_d = (pend_q != select_q);
    end
    if (xfer) begin
      pend_d    = sanitize_mode(cfg_mode);
      pending_d = 1'b1;
    end else if (press) begin
      pend_d    = next_mode(base_mode);
      pending_d = 1'b1;
    end
  end

  // Mode, queue and vsync history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q      <= VS_IDLE;
      select_q  <= MODE_NORMAL;
      pend_q    <= MODE_NORMAL;
      pending_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      vs_q      <= vsync;
      select_q  <= select_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      changed_q <= changed_d;
    end
  end

  assign select       = select_q;
  assign pending      = pending_q;
  assign cfg_ready    = ~pending_q;
  assign mode_changed = changed_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl: directed stimulus pushes the expected commit
// result per frame boundary; a monitor pops it one cycle after the edge.
module tb_filter_mode_ctrl;
  import filter_pkg::*;

  // Clock and reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       vsync = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'b00;
  logic       cfg_ready;
  logic [1:0] select;
  logic       pending;
  logic       mode_changed;

  always #5 clk = ~clk;

  filter_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .VS_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .vsync       (vsync),
    .cfg_valid   (cfg_valid),
    .cfg_mode    (cfg_mode),
    .cfg_ready   (cfg_ready),
    .select      (select),
    .pending     (pending),
    .mode_changed(mode_changed)
  );

  // Scoreboard: {select, mode_changed, pending} expected after each boundary
  logic [3:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit post_bnd = 1'b0;
  logic vs_prev = 1'b1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: independent boundary detection (vsync falling edge)
  always @(posedge clk) begin
    post_bnd = !reset && vs_prev && !vsync;
    vs_prev  = reset ? 1'b1 : vsync;
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (post_bnd) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL boundary_unexpected: got select=%b mc=%b pending=%b expected no boundary",
                 select, mode_changed, pending);
      end else begin
        e = exp_q.pop_front();
        check("boundary_commit", {select, mode_changed, pending}, e);
      end
    end else if (!reset) begin
      check("mc_idle", {3'b000, mode_changed}, 4'b0000);
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn = 1'b0;
    vsync = 1'b1;
    cfg_valid = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic press();
    btn = 1'b1;
    tick(8);
    btn = 1'b0;
    tick(8);
  endtask

  task automatic frame(input logic [1:0] sel, input logic mc, input logic pend);
    exp_q.push_back({sel, mc, pend});
    vsync = 1'b0;
    tick(3);
    vsync = 1'b1;
    tick(2);
  endtask

  task automatic cfg(input logic [1:0] m);
    cfg_valid = 1'b1;
    cfg_mode = m;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_select", {2'b00, select}, {2'b00, MODE_NORMAL});
    check("rst_pending", {3'b000, pending}, 4'b0000);
    check("rst_cfg_ready", {3'b000, cfg_ready}, 4'b0001);
    check("rst_mode_changed", {3'b000, mode_changed}, 4'b0000);

    // Single press then boundary: 00 -> 01 with one pulse
    press();
    check("press_pending", {3'b000, pending}, 4'b0001);
    check("press_cfg_ready", {3'b000, cfg_ready}, 4'b0000);
    frame(MODE_GRAY, 1'b1, 1'b0);
    check("after_frame_cfg_ready", {3'b000, cfg_ready}, 4'b0001);

    // Three presses wrap back to 00: no change, pending clears
    do_reset();
    press();
    press();
    press();
    frame(MODE_NORMAL, 1'b0, 1'b0);

    // 3-cycle glitch is filtered
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(10);
    check("glitch_pending", {3'b000, pending}, 4'b0000);
    frame(MODE_NORMAL, 1'b0, 1'b0);

    // Host request 11 maps to 00; a second request waits for the boundary
    cfg(2'b11);
    check("cfg_pending", {3'b000, pending}, 4'b0001);
    check("cfg_ready_low", {3'b000, cfg_ready}, 4'b0000);
    cfg_valid = 1'b1;
    cfg_mode = MODE_NEG;
    tick(3);
    check("held_off_pending", {3'b000, pending}, 4'b0001);
    frame(MODE_NORMAL, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    check("held_req_taken", {3'b000, pending}, 4'b0001);
    frame(MODE_NEG, 1'b1, 1'b0);

    // Press coinciding with boundary while 10 is queued
    do_reset();
    cfg(MODE_NEG);
    btn = 1'b1;
    tick(6);
    exp_q.push_back({MODE_NEG, 1'b1, 1'b1});
    vsync = 1'b0;
    tick(1);
    vsync = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(8);
    check("bnd_press_pending", {3'b000, pending}, 4'b0001);
    frame(MODE_NORMAL, 1'b1, 1'b0);

    // Press coinciding with host transfer of 01: host wins
    cfg(MODE_NEG);
    frame(MODE_NEG, 1'b1, 1'b0);
    btn = 1'b1;
    tick(6);
    cfg_valid = 1'b1;
    cfg_mode = MODE_GRAY;
    tick(1);
    cfg_valid = 1'b0;
    check("press_cfg_pending", {3'b000, pending}, 4'b0001);
    tick(1);
    btn = 1'b0;
    tick(8);
    frame(MODE_GRAY, 1'b1, 1'b0);

    // Reset mid-operation: queued mode and debounce progress discarded
    cfg(MODE_NEG);
    btn = 1'b1;
    tick(4);
    reset = 1'b1;
    btn = 1'b0;
    tick(1);
    reset = 1'b0;
    check("midrst_select", {2'b00, select}, {2'b00, MODE_NORMAL});
    check("midrst_pending", {3'b000, pending}, 4'b0000);
    check("midrst_cfg_ready", {3'b000, cfg_ready}, 4'b0001);
    check("midrst_mode_changed", {3'b000, mode_changed}, 4'b0000);
    tick(10);
    check("midrst_no_press", {3'b000, pending}, 4'b0000);
    frame(MODE_NORMAL, 1'b0, 1'b0);

    // Final report
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
